// File: rtl/id_ex_hazard_pipe_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_pipe_if
// Bundle between the ID stage (decoder + register file) and the ID/EX
// pipeline register.
//
// Handshake: id_valid marks a real instruction on the id_* fields. stall is
// the back-pressure: while stall=1 the upstream stages (PC, IF/ID) hold, so
// the same ID instruction is presented again on the next cycle. ex_valid
// marks a real instruction on the ex_* fields; ex_valid=0 is a bubble.
//
// Modports:
//   master - ID side: drives id_*, flush; observes stall, ex_*, bubble_count
//   slave  - pipeline register: the reverse directions
// ---------------------------------------------------------------------------
interface id_ex_hazard_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    // ID side
    logic              id_valid;
    logic              flush;
    logic              id_mem_to_reg;
    logic              id_jump;
    logic              id_mem_to_write;
    logic [2:0]        id_alu_op;
    logic              id_reg_write;
    logic              id_reg_dst;
    logic              id_branch;
    logic              id_mem_read;
    logic              id_alu_src;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [5:0]        id_funct;

    // Hazard / EX side
    logic              stall;
    logic              ex_valid;
    logic              ex_mem_to_reg;
    logic              ex_jump;
    logic              ex_mem_to_write;
    logic [2:0]        ex_alu_op;
    logic              ex_reg_write;
    logic              ex_reg_dst;
    logic              ex_branch;
    logic              ex_mem_read;
    logic              ex_alu_src;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [5:0]        ex_funct;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, flush, id_mem_to_reg, id_jump, id_mem_to_write,
               id_alu_op, id_reg_write, id_reg_dst, id_branch, id_mem_read,
               id_alu_src, id_rs_data, id_rt_data, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_funct,
        input  stall, ex_valid, ex_mem_to_reg, ex_jump, ex_mem_to_write,
               ex_alu_op, ex_reg_write, ex_reg_dst, ex_branch, ex_mem_read,
               ex_alu_src, ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
               ex_rs, ex_rt, ex_rd, ex_funct, bubble_count
    );

    modport slave (
        input  id_valid, flush, id_mem_to_reg, id_jump, id_mem_to_write,
               id_alu_op, id_reg_write, id_reg_dst, id_branch, id_mem_read,
               id_alu_src, id_rs_data, id_rt_data, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_funct,
        output stall, ex_valid, ex_mem_to_reg, ex_jump, ex_mem_to_write,
               ex_alu_op, ex_reg_write, ex_reg_dst, ex_branch, ex_mem_read,
               ex_alu_src, ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
               ex_rs, ex_rt, ex_rd, ex_funct, bubble_count
    );
endinterface

// File: rtl/id_ex_hazard_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_pipe
// ID/EX pipeline register with load-use hazard detection.
//   - Latches decoder controls, operands, immediate, PC+4 and register
//     addresses into EX one clock after they are presented.
//   - Raises a combinational stall when the instruction in ID reads the
//     destination of a load sitting in EX, and inserts a one-cycle bubble.
//   - Flush (branch taken / jump) and invalid ID also produce bubbles; only
//     hazard bubbles are counted, in a saturating counter.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - id_ex_hazard_pipe_if.slave (ID inputs, stall, ex_* outputs,
//         bubble_count)
// ---------------------------------------------------------------------------
module id_ex_hazard_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    id_ex_hazard_pipe_if.slave bus
);

    typedef struct packed {
        logic       mem_to_reg;
        logic       jump;
        logic       mem_to_write;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       alu_src;
    } ctrl_t;

    ctrl_t             id_ctrl;
    logic              uses_rt;
    logic              hazard;

    logic              ex_valid_d,     ex_valid_q;
    ctrl_t             ctrl_d,         ctrl_q;
    logic [DATA_W-1:0] rs_data_d,      rs_data_q;
    logic [DATA_W-1:0] rt_data_d,      rt_data_q;
    logic [DATA_W-1:0] imm_d,          imm_q;
    logic [DATA_W-1:0] pc4_d,          pc4_q;
    logic [REG_W-1:0]  rs_d,           rs_q;
    logic [REG_W-1:0]  rt_d,           rt_q;
    logic [REG_W-1:0]  rd_d,           rd_q;
    logic [5:0]        funct_d,        funct_q;
    logic [CNT_W-1:0]  bubble_count_d, bubble_count_q;

    always_comb begin
        id_ctrl = '{
            mem_to_reg:   bus.id_mem_to_reg,
            jump:         bus.id_jump,
            mem_to_write: bus.id_mem_to_write,
            alu_op:       bus.id_alu_op,
            reg_write:    bus.id_reg_write,
            reg_dst:      bus.id_reg_dst,
            branch:       bus.id_branch,
            mem_read:     bus.id_mem_read,
            alu_src:      bus.id_alu_src
        };

        // rt is a source unless the instruction writes rt from an immediate
        // (I-type ALU ops and loads). Stores have RegWrite=0, so rt counts.
        uses_rt = ~bus.id_alu_src | ~bus.id_reg_write;

        // A load into $0 produces nothing a consumer could wait on. Jumps
        // read no registers in EX, so they never wait on a load.
        hazard = ex_valid_q & ctrl_q.mem_to_reg & (rt_q != '0) &
                 bus.id_valid & ~bus.id_jump &
                 ((rt_q == bus.id_rs) | (uses_rt & (rt_q == bus.id_rt)));

        // Defaults: bubble with data fields following ID (don't-care when
        // ex_valid=0), counter unchanged.
        ex_valid_d     = 1'b0;
        ctrl_d         = '0;
        rs_data_d      = bus.id_rs_data;
        rt_data_d      = bus.id_rt_data;
        imm_d          = bus.id_imm;
        pc4_d          = bus.id_pc4;
        rs_d           = bus.id_rs;
        rt_d           = bus.id_rt;
        rd_d           = bus.id_rd;
        funct_d        = bus.id_funct;
        bubble_count_d = bubble_count_q;

        if (bus.flush) begin
            // Squashed instruction: bubble, not a hazard bubble.
        end else if (hazard) begin
            if (bubble_count_q != '1) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else if (bus.id_valid) begin
            ex_valid_d = 1'b1;
            ctrl_d     = id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ctrl_q         <= '0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
            pc4_q          <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            funct_q        <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ctrl_q         <= ctrl_d;
            rs_data_q      <= rs_data_d;
            rt_data_q      <= rt_data_d;
            imm_q          <= imm_d;
            pc4_q          <= pc4_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            funct_q        <= funct_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // Flush wins over a hazard: the consumer is being squashed anyway.
    assign bus.stall           = hazard & ~bus.flush & ~rst;
    assign bus.ex_valid        = ex_valid_q;
    assign bus.ex_mem_to_reg   = ctrl_q.mem_to_reg;
    assign bus.ex_jump         = ctrl_q.jump;
    assign bus.ex_mem_to_write = ctrl_q.mem_to_write;
    assign bus.ex_alu_op       = ctrl_q.alu_op;
    assign bus.ex_reg_write    = ctrl_q.reg_write;
    assign bus.ex_reg_dst      = ctrl_q.reg_dst;
    assign bus.ex_branch       = ctrl_q.branch;
    assign bus.ex_mem_read     = ctrl_q.mem_read;
    assign bus.ex_alu_src      = ctrl_q.alu_src;
    assign bus.ex_rs_data      = rs_data_q;
    assign bus.ex_rt_data      = rt_data_q;
    assign bus.ex_imm          = imm_q;
    assign bus.ex_pc4          = pc4_q;
    assign bus.ex_rs           = rs_q;
    assign bus.ex_rt           = rt_q;
    assign bus.ex_rd           = rd_q;
    assign bus.ex_funct        = funct_q;
    assign bus.bubble_count    = bubble_count_q;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_pipe
// Directed bench for id_ex_hazard_pipe. Each step drives one ID instruction,
// checks stall before the edge, pushes the expected EX bundle, then pops and
// compares it after the edge. A small reference model tracks the EX load
// state and the bubble counter.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int CTRL_W = 11;
    localparam int DATA_F = 4*DATA_W + 3*REG_W + 6;
    localparam int EXP_W  = 1 + CTRL_W + DATA_F;

    typedef struct packed {
        logic              valid;
        logic              flush;
        logic              mem_to_reg;
        logic              jump;
        logic              mem_to_write;
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              reg_dst;
        logic              branch;
        logic              mem_read;
        logic              alu_src;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
    } ins_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_hazard_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_hazard_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard / model ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               n_vec;
    int               n_err;

    logic             m_valid;
    logic             m_mtr;
    logic [REG_W-1:0] m_rt;
    logic [CNT_W-1:0] m_cnt;

    function automatic ins_t mk(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                input logic [REG_W-1:0] rd);
        ins_t t;
        t         = '0;
        t.valid   = 1'b1;
        t.rs      = rs;
        t.rt      = rt;
        t.rd      = rd;
        t.rs_data = $urandom;
        t.rt_data = $urandom;
        t.imm     = $urandom;
        t.pc4     = $urandom;
        t.funct   = 6'($urandom_range(0, 63));
        return t;
    endfunction

    function automatic ins_t rtype(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                   input logic [REG_W-1:0] rd);
        ins_t t;
        t           = mk(rs, rt, rd);
        t.alu_op    = 3'b010;
        t.reg_dst   = 1'b1;
        t.reg_write = 1'b1;
        t.funct     = 6'h20;
        return t;
    endfunction

    function automatic ins_t lw(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        ins_t t;
        t            = mk(rs, rt, 5'd0);
        t.mem_to_reg = 1'b1;
        t.mem_read   = 1'b1;
        t.reg_write  = 1'b1;
        t.alu_src    = 1'b1;
        return t;
    endfunction

    function automatic ins_t addi(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        ins_t t;
        t           = mk(rs, rt, 5'd0);
        t.reg_write = 1'b1;
        t.alu_src   = 1'b1;
        return t;
    endfunction

    function automatic ins_t sw(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        ins_t t;
        t              = mk(rs, rt, 5'd0);
        t.mem_to_write = 1'b1;
        t.alu_src      = 1'b1;
        return t;
    endfunction

    function automatic logic [EXP_W-1:0] pack_exp(input ins_t t, input logic v);
        logic [CTRL_W-1:0] c;
        c = {t.mem_to_reg, t.jump, t.mem_to_write, t.alu_op, t.reg_write,
             t.reg_dst, t.branch, t.mem_read, t.alu_src};
        if (!v) c = '0;
        return {v, c, t.rs_data, t.rt_data, t.imm, t.pc4, t.rs, t.rt, t.rd, t.funct};
    endfunction

    function automatic logic [EXP_W-1:0] obs_vec();
        return {bus.ex_valid, bus.ex_mem_to_reg, bus.ex_jump, bus.ex_mem_to_write,
                bus.ex_alu_op, bus.ex_reg_write, bus.ex_reg_dst, bus.ex_branch,
                bus.ex_mem_read, bus.ex_alu_src, bus.ex_rs_data, bus.ex_rt_data,
                bus.ex_imm, bus.ex_pc4, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input ins_t t);
        bus.id_valid        = t.valid;
        bus.flush           = t.flush;
        bus.id_mem_to_reg   = t.mem_to_reg;
        bus.id_jump         = t.jump;
        bus.id_mem_to_write = t.mem_to_write;
        bus.id_alu_op       = t.alu_op;
        bus.id_reg_write    = t.reg_write;
        bus.id_reg_dst      = t.reg_dst;
        bus.id_branch       = t.branch;
        bus.id_mem_read     = t.mem_read;
        bus.id_alu_src      = t.alu_src;
        bus.id_rs_data      = t.rs_data;
        bus.id_rt_data      = t.rt_data;
        bus.id_imm          = t.imm;
        bus.id_pc4          = t.pc4;
        bus.id_rs           = t.rs;
        bus.id_rt           = t.rt;
        bus.id_rd           = t.rd;
        bus.id_funct        = t.funct;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_mtr   = 1'b0;
        m_rt    = '0;
        m_cnt   = '0;
    endtask

    // One instruction through one clock: stall check, push, edge, pop/compare.
    task automatic apply(input ins_t t, input string tag);
        logic             ur;
        logic             hz;
        logic             exp_stall;
        logic             v;
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] o;

        drive(t);
        #1;
        ur        = ~t.alu_src | ~t.reg_write;
        hz        = m_valid & m_mtr & (m_rt != 0) & t.valid & ~t.jump &
                    ((m_rt == t.rs) | (ur & (m_rt == t.rt)));
        exp_stall = hz & ~t.flush;
        n_vec++;
        assert (bus.stall === exp_stall) else begin
            n_err++;
            $error("FAIL %s_stall observed=%0b expected=%0b", tag, bus.stall, exp_stall);
        end

        v = ~(t.flush | hz | ~t.valid);
        exp_q.push_back(pack_exp(t, v));
        if (hz && !t.flush && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_valid = v;
        m_mtr   = v & t.mem_to_reg;
        m_rt    = t.rt;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = obs_vec();
        n_vec++;
        assert (o[EXP_W-1 -: 1+CTRL_W] === e[EXP_W-1 -: 1+CTRL_W]) else begin
            n_err++;
            $error("FAIL %s_ctrl observed=%h expected=%h", tag,
                   o[EXP_W-1 -: 1+CTRL_W], e[EXP_W-1 -: 1+CTRL_W]);
        end
        if (e[EXP_W-1]) begin
            n_vec++;
            assert (o[DATA_F-1:0] === e[DATA_F-1:0]) else begin
                n_err++;
                $error("FAIL %s_data observed=%h expected=%h", tag, o[DATA_F-1:0], e[DATA_F-1:0]);
            end
        end
        n_vec++;
        assert (bus.bubble_count === m_cnt) else begin
            n_err++;
            $error("FAIL %s_count observed=%h expected=%h", tag, bus.bubble_count, m_cnt);
        end
    endtask

    task automatic check_reset(input string tag);
        logic [EXP_W-1:0] o;
        o = obs_vec();
        n_vec++;
        assert (o === '0) else begin
            n_err++;
            $error("FAIL %s_ex observed=%h expected=0", tag, o);
        end
        n_vec++;
        assert (bus.bubble_count === '0) else begin
            n_err++;
            $error("FAIL %s_count observed=%h expected=0", tag, bus.bubble_count);
        end
        n_vec++;
        assert (bus.stall === 1'b0) else begin
            n_err++;
            $error("FAIL %s_stall observed=%b expected=0", tag, bus.stall);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        ins_t t;
        n_vec = 0;
        n_err = 0;
        model_reset();
        drive('0);
        rst = 1'b1;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Pass-through R-type
        t          = rtype(5'd9, 5'd10, 5'd11);
        t.alu_op   = 3'b001;
        t.rs_data  = 32'h5;
        t.rt_data  = 32'h7;
        apply(t, "pass");

        // Load-use on rs: one stall, bubble, then the add is captured
        apply(lw(5'd4, 5'd8), "lw8");
        t = rtype(5'd8, 5'd3, 5'd12);
        apply(t, "use_rs_stall");
        apply(t, "use_rs_held");

        // Load into $0 never stalls
        apply(lw(5'd4, 5'd0), "lw0");
        apply(rtype(5'd0, 5'd0, 5'd13), "use_r0");

        // addi writes rt from the immediate: rt is not a source
        apply(lw(5'd4, 5'd8), "lw8b");
        apply(addi(5'd9, 5'd8), "addi_nostall");

        // sw reads rt: stalls
        apply(lw(5'd4, 5'd8), "lw8c");
        t = sw(5'd9, 5'd8);
        apply(t, "sw_stall");
        apply(t, "sw_held");

        // R-type consuming via rt
        apply(lw(5'd1, 5'd17), "lw17");
        t = rtype(5'd2, 5'd17, 5'd18);
        apply(t, "use_rt_stall");
        apply(t, "use_rt_held");

        // Flush beats hazard
        apply(lw(5'd4, 5'd8), "lw8d");
        t       = rtype(5'd8, 5'd8, 5'd14);
        t.flush = 1'b1;
        apply(t, "flush_hazard");

        // Jump in ID never waits on a load
        apply(lw(5'd4, 5'd8), "lw8e");
        t      = mk(5'd8, 5'd8, 5'd0);
        t.jump = 1'b1;
        apply(t, "jump_nostall");

        // Invalid ID after a load: bubble, not counted
        apply(lw(5'd4, 5'd8), "lw8f");
        t       = rtype(5'd8, 5'd8, 5'd15);
        t.valid = 1'b0;
        apply(t, "invalid_id");

        // Random mix of loads and R-types
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                t = lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else
                t = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)));
            t.flush = ($urandom_range(0, 7) == 0);
            apply(t, "rand");
        end

        // Saturation: preload the counter just below the top
        @(negedge clk);
        force dut.bubble_count_q = 16'hFFFE;
        #1;
        release dut.bubble_count_q;
        m_cnt = 16'hFFFE;
        apply(lw(5'd4, 5'd8), "sat_lw1");
        t = rtype(5'd8, 5'd1, 5'd2);
        apply(t, "sat_to_ffff");
        apply(t, "sat_held1");
        apply(lw(5'd4, 5'd8), "sat_lw2");
        apply(t, "sat_stays");
        apply(t, "sat_held2");

        // Async reset between edges with a valid instruction in EX
        apply(rtype(5'd5, 5'd6, 5'd7), "pre_rst");
        apply(lw(5'd4, 5'd8), "pre_rst_lw");
        drive(rtype(5'd8, 5'd1, 5'd3));
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(rtype(5'd8, 5'd1, 5'd3), "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_pipe.md
Name: id_ex_hazard_pipe

Overview:
ID/EX pipeline register for the pipelined MIPS datapath, directly downstream of the opcode control decoder.
- Latches the decoder's control bundle plus register-file operands, immediate and register addresses into the EX stage.
- Detects load-use hazards against the instruction currently in EX and drives a stall to the PC and IF/ID registers.
- Inserts a one-cycle bubble on a stall or on a branch/jump flush, and counts hazard bubbles for performance monitoring.

Parameters:
DATA_W, 32, width of operand, immediate and PC+4 fields
REG_W, 5, register address width
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
flush  in  1  squash ID instruction (branch taken / jump resolved)
id_mem_to_reg  in  1  decoder MemToReg (1 = load)
id_jump  in  1  decoder jump
id_mem_to_write  in  1  decoder MemToWrite
id_alu_op  in  3  decoder AluOp
id_reg_write  in  1  decoder RegWrite
id_reg_dst  in  1  decoder RegDst
id_branch  in  1  decoder Branch
id_mem_read  in  1  decoder MemRead
id_alu_src  in  1  decoder AluSrc
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of ID instruction
id_rs, id_rt, id_rd  in  REG_W  register addresses
id_funct  in  6  funct field
stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_mem_to_reg, ex_jump, ex_mem_to_write, ex_reg_write, ex_reg_dst, ex_branch, ex_mem_read, ex_alu_src  out  1 each  registered controls
ex_alu_op  out  3  registered AluOp
ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered data
ex_rs, ex_rt, ex_rd  out  REG_W  registered addresses
ex_funct  out  6  registered funct
bubble_count  out  CNT_W  number of hazard bubbles inserted

Behaviour:
- Reset:
  - rst=1 immediately forces every ex_* output, ex_valid and bubble_count to 0, independent of clk.
  - stall is 0 while rst=1.
- Latency: all ex_* fields update on the rising clk edge, one cycle after the ID inputs are presented.
- Hazard detection (combinational):
  - uses_rt = ~id_alu_src | ~id_reg_write.
  - hazard = ex_valid & ex_mem_to_reg & (ex_rt != 0) & id_valid & ~id_jump & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt))).
  - stall = hazard & ~flush & ~rst.
- Next-state select at each clk edge, in priority order:
  - 1. flush=1 -> bubble.
  - 2. hazard=1 -> bubble, and bubble_count increments.
  - 3. id_valid=0 -> bubble.
  - 4. Otherwise capture all ID inputs; ex_valid=1.
- Bubble definition:
  - ex_valid=0; all control outputs (including ex_alu_op) = 0.
  - Data and address fields still capture the ID inputs; their value is don't-care for a bubble.
- Single-cycle stall guarantee: after a bubble ex_valid=0, so the same pair cannot stall twice. The held ID instruction is captured on the following edge.
- bubble_count:
  - Counts hazard bubbles only; flush and invalid bubbles are not counted.
  - Saturates at 2^CNT_W-1 and never wraps.
- Simultaneous flush and hazard: flush wins. stall=0, a bubble is inserted, and the counter does not change.
- Register 0: a load targeting $0 never causes a stall.
- No forwarding is performed here; the forwarding unit consumes ex_rs/ex_rt.

Test Plan:
- Async reset: run a valid R-type through EX, then assert rst between edges -> all ex_* outputs, ex_valid and bubble_count read 0 before the next edge; stall=0.
- Pass-through: R-type with rs=9, rt=10, rd=11, funct=0x20, AluOp=001, RegDst=1, RegWrite=1, rs_data=0x5, rt_data=0x7 -> next edge ex_valid=1 and all fields equal the inputs.
- Load-use hazard:
  - Stimulus: lw with rt=8 (MemToReg=1) in EX, then add with rs=8.
  - Required response: stall=1 for exactly one cycle.
  - Next edge: ex_valid=0, controls 0, bubble_count=1.
  - Following edge: add captured and stall=0.
- No false stall:
  - lw rt=0 followed by a consumer of rs=0 -> stall=0.
  - lw rt=8 followed by addi with rs=9, rt=8 (AluSrc=1, RegWrite=1) -> stall=0.
  - lw rt=8 followed by sw with rt=8 (RegWrite=0) -> stall=1.
- Flush priority: load-use hazard with flush=1 in the same cycle -> stall=0, bubble inserted, bubble_count unchanged.
- Saturation: preload bubble_count to 0xFFFE via repeated hazards (or force), apply two more hazards -> 0xFFFF then stays at 0xFFFF.
